// File: rtl/result_packer.sv
// Serializes one measurement record (tag, 48-bit timestamp, 14-bit ADC sample) into
// five 16-bit FIFO words with a 12-bit sequence number, honouring FIFO backpressure.
//
// state | meaning
// IDLE  | waiting for a record; rec_ready high
// W0    | presenting {tag, seq}
// W1    | presenting time[47:32]
// W2    | presenting time[31:16]
// W3    | presenting time[15:0]
// W4    | presenting {2'b00, adc}; seq advances when written
module result_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_valid,
  input  logic [3:0]  rec_tag,
  input  logic [47:0] rec_time,
  input  logic [13:0] rec_adc,
  output logic        rec_ready,
  input  logic        fifo_full,
  output logic        data_write,
  output logic [15:0] data_out,
  output logic [15:0] drop_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_W0   = 4'd1,
    S_W1   = 4'd2,
    S_W2   = 4'd3,
    S_W3   = 4'd4,
    S_W4   = 4'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_tag;
  logic [47:0] r_time;
  logic [13:0] r_adc;
  logic [11:0] r_seq;
  logic [15:0] r_drop_count;
  logic        w_capture;
  logic        w_drop;

  assign rec_ready  = (r_state == S_IDLE);
  assign w_capture  = rec_valid && rec_ready;
  assign w_drop     = rec_valid && !rec_ready;
  assign drop_count = r_drop_count;
  assign state      = r_state;

  // Each word state writes only when the FIFO has room and advances on that same edge.
  always_comb begin
    w_next_state = r_state;
    data_write   = 1'b0;
    data_out     = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next_state = S_W0;
      end
      S_W0: begin
        data_write = !fifo_full;
        data_out   = {r_tag, r_seq};
        if (!fifo_full) w_next_state = S_W1;
      end
      S_W1: begin
        data_write = !fifo_full;
        data_out   = r_time[47:32];
        if (!fifo_full) w_next_state = S_W2;
      end
      S_W2: begin
        data_write = !fifo_full;
        data_out   = r_time[31:16];
        if (!fifo_full) w_next_state = S_W3;
      end
      S_W3: begin
        data_write = !fifo_full;
        data_out   = r_time[15:0];
        if (!fifo_full) w_next_state = S_W4;
      end
      S_W4: begin
        data_write = !fifo_full;
        data_out   = {2'b00, r_adc};
        if (!fifo_full) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_time       <= '0;
      r_adc        <= '0;
      r_seq        <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_tag  <= rec_tag;
        r_time <= rec_time;
        r_adc  <= rec_adc;
      end
      if (r_state == S_W4 && data_write) r_seq <= r_seq + 12'd1;
      if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios plus randomized traffic
// compared against a word-queue reference model of the record stream.
module tb_result_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rec_valid = 1'b0;
  logic [3:0]  rec_tag = '0;
  logic [47:0] rec_time = '0;
  logic [13:0] rec_adc = '0;
  logic        rec_ready;
  logic        fifo_full = 1'b0;
  logic        data_write;
  logic [15:0] data_out;
  logic [15:0] drop_count;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  // Reference model: words still owed for the current record, the record's words,
  // next sequence number and saturating drop total.
  int          m_pending = 0;
  logic [15:0] m_words[5];
  int          m_seq = 0;
  int          m_drops = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  result_packer dut (
    .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_tag(rec_tag),
    .rec_time(rec_time), .rec_adc(rec_adc), .rec_ready(rec_ready),
    .fifo_full(fifo_full), .data_write(data_write), .data_out(data_out),
    .drop_count(drop_count), .state(state)
  );

  always #5 clk = ~clk;

  // Whatever the FIFO would write at the coming edge.
  always @(negedge clk) if (data_write === 1'b1) obs_q.push_back(data_out);

  task automatic cycle();
    bit busy;
    @(posedge clk);
    busy = (m_pending > 0);
    if (busy && !fifo_full) begin
      exp_q.push_back(m_words[5 - m_pending]);
      m_pending--;
      if (m_pending == 0) m_seq = (m_seq + 1) % 4096;
    end
    if (rst) begin
      m_pending = 0;
      m_seq     = 0;
      m_drops   = 0;
    end else if (rec_valid) begin
      if (!busy) begin
        m_words[0] = {rec_tag, 12'(m_seq)};
        m_words[1] = rec_time[47:32];
        m_words[2] = rec_time[31:16];
        m_words[3] = rec_time[15:0];
        m_words[4] = {2'b00, rec_adc};
        m_pending  = 5;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
    #1;
  endtask

  task automatic set_rec(input logic [3:0] t, input logic [47:0] tm, input logic [13:0] a);
    rec_tag  = t;
    rec_time = tm;
    rec_adc  = a;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rec_valid = 1'b0; fifo_full = 1'b0;
    cycle(); cycle();
    rst = 1'b0; #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (data_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b want=0", data_write); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h want=0000", data_out); end
    checks++; if (rec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", rec_ready); end
    checks++; if (drop_count !== 16'h0000) begin errors++; $display("FAIL reset_drops got=%h want=0000", drop_count); end
    clear_queues();
  endtask

  task automatic test_basic();
    logic [15:0] lit[5] = '{16'h1000, 16'h0123, 16'h4567, 16'h89AB, 16'h1ABC};
    set_rec(4'h1, 48'h0123_4567_89AB, 14'h1ABC);
    rec_valid = 1'b1; cycle(); rec_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (data_write !== 1'b1 || data_out !== lit[i]) begin
        errors++; $display("FAIL basic_word%0d got we=%b data=%h want we=1 data=%h", i, data_write, data_out, lit[i]);
      end
      cycle();
    end
    #1;
    checks++; if (data_write !== 1'b0) begin errors++; $display("FAIL basic_done_write got=%b want=0", data_write); end
    checks++; if (rec_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b want=1", rec_ready); end
    checks++; if (drop_count !== 16'h0000) begin errors++; $display("FAIL basic_drops got=%h want=0000", drop_count); end
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL basic_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== lit[i]) begin errors++; $display("FAIL basic_stream%0d got=%h want=%h", i, obs_q[i], lit[i]); end
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [15:0] lit[5] = '{16'h1001, 16'h0123, 16'h4567, 16'h89AB, 16'h1ABC};
    set_rec(4'h1, 48'h0123_4567_89AB, 14'h1ABC);
    rec_valid = 1'b1; cycle(); rec_valid = 1'b0;
    cycle(); cycle();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (data_write !== 1'b0 || data_out !== 16'h4567 || state !== 4'd3) begin
        errors++; $display("FAIL bp_hold%0d got we=%b data=%h st=%0d want we=0 data=4567 st=3", i, data_write, data_out, state);
      end
      cycle();
    end
    fifo_full = 1'b0;
    for (int i = 2; i < 5; i++) begin
      #1;
      checks++;
      if (data_write !== 1'b1 || data_out !== lit[i]) begin
        errors++; $display("FAIL bp_word%0d got we=%b data=%h want we=1 data=%h", i, data_write, data_out, lit[i]);
      end
      cycle();
    end
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL bp_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== lit[i]) begin errors++; $display("FAIL bp_stream%0d got=%h want=%h", i, obs_q[i], lit[i]); end
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    rst = 1'b1; cycle(); rst = 1'b0;
    clear_queues();
    set_rec(4'($urandom), {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 14'($urandom));
    rec_valid = 1'b1;
    repeat (12) cycle();
    rec_valid = 1'b0;
    repeat (6) cycle();
    checks++; if (drop_count !== 16'd10) begin errors++; $display("FAIL b2b_drops got=%0d want=10", drop_count); end
    checks++; if (obs_q.size() != 10) begin errors++; $display("FAIL b2b_count got=%0d want=10", obs_q.size()); end
    if (obs_q.size() == 10) begin
      w = obs_q[0];
      checks++; if (w[11:0] !== 12'h000) begin errors++; $display("FAIL b2b_seq0 got=%h want=000", w[11:0]); end
      w = obs_q[5];
      checks++; if (w[11:0] !== 12'h001) begin errors++; $display("FAIL b2b_seq1 got=%h want=001", w[11:0]); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_stream%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    set_rec(4'h7, 48'hAAAA_BBBB_CCCC, 14'h0555);
    rec_valid = 1'b1; cycle(); rec_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b1; rec_valid = 1'b1;
    cycle();
    rst = 1'b0; rec_valid = 1'b0; #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rstmid_state got=%0d want=0", state); end
    checks++; if (data_write !== 1'b0) begin errors++; $display("FAIL rstmid_write got=%b want=0", data_write); end
    checks++; if (rec_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", rec_ready); end
    checks++; if (drop_count !== 16'h0000) begin errors++; $display("FAIL rstmid_drops got=%h want=0000", drop_count); end
    set_rec(4'h9, 48'h1111_2222_3333, 14'h0444);
    rec_valid = 1'b1; cycle(); rec_valid = 1'b0; #1;
    checks++;
    if (data_write !== 1'b1 || data_out !== 16'h9000) begin
      errors++; $display("FAIL rstmid_w0 got we=%b data=%h want we=1 data=9000", data_write, data_out);
    end
    repeat (6) cycle();
    clear_queues();
  endtask

  task automatic test_random();
    logic [15:0] e_do;
    clear_queues();
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      rec_valid = ($urandom_range(0, 2) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      set_rec(4'($urandom), {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 14'($urandom));
      #1;
      e_do = (m_pending > 0) ? m_words[5 - m_pending] : 16'h0000;
      checks++;
      if (data_write !== ((m_pending > 0) && !fifo_full)) begin
        errors++; $display("FAIL rand_write cyc=%0d got=%b want=%b", n, data_write, (m_pending > 0) && !fifo_full);
      end
      checks++; if (data_out !== e_do) begin errors++; $display("FAIL rand_data cyc=%0d got=%h want=%h", n, data_out, e_do); end
      checks++;
      if (rec_ready !== (m_pending == 0)) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", n, rec_ready, m_pending == 0); end
      checks++;
      if (drop_count !== 16'(m_drops)) begin errors++; $display("FAIL rand_drops cyc=%0d got=%0d want=%0d", n, drop_count, m_drops); end
      cycle();
    end
    rst = 1'b0; rec_valid = 1'b0; fifo_full = 1'b0;
    repeat (6) cycle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_stream%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    clear_queues();
  endtask

  task automatic test_wrap_and_saturation();
    logic [15:0] w;
    int guard;
    rst = 1'b1; cycle(); rst = 1'b0;
    clear_queues();
    set_rec(4'hC, 48'hDEAD_BEEF_CAFE, 14'h2A5A);
    rec_valid = 1'b1;
    repeat (4097 * 6) cycle();
    checks++; if (obs_q.size() != 4097 * 5) begin errors++; $display("FAIL wrap_count got=%0d want=%0d", obs_q.size(), 4097 * 5); end
    if (obs_q.size() == 4097 * 5) begin
      w = obs_q[5 * 4095];
      checks++; if (w[11:0] !== 12'hFFF) begin errors++; $display("FAIL wrap_rec4096 got=%h want=fff", w[11:0]); end
      w = obs_q[5 * 4096];
      checks++; if (w[11:0] !== 12'h000) begin errors++; $display("FAIL wrap_rec4097 got=%h want=000", w[11:0]); end
    end
    checks++; if (drop_count !== 16'd20485) begin errors++; $display("FAIL wrap_drops got=%0d want=20485", drop_count); end
    clear_queues();
    // Stall in W0 so every edge is a refused request until the counter saturates.
    fifo_full = 1'b1;
    guard = 0;
    while (m_drops < 65535 && guard < 50000) begin
      cycle();
      guard++;
    end
    checks++; if (guard >= 50000) begin errors++; $display("FAIL sat_timeout got=%0d want=65535", m_drops); end
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (drop_count !== 16'hFFFF || state !== 4'd1) begin
        errors++; $display("FAIL sat_hold%0d got drops=%h st=%0d want drops=ffff st=1", i, drop_count, state);
      end
    end
    rec_valid = 1'b0; fifo_full = 1'b0;
    repeat (6) cycle();
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%h want=ffff", drop_count); end
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL sat_flush_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_stream%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap_and_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
